// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding, default word
// width and the fixed SPI mode (mode 0: CPOL=0, CPHA=0).
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_t;

  localparam int   SPI_DATA_W = 8;
  localparam logic SPI_CPOL   = 1'b0;
  localparam logic SPI_CPHA   = 1'b0;

  // Synchronisers shorter than this are not metastability-safe.
  localparam int SPI_SYNC_MIN = 2;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for one asynchronous input, plus single-cycle
// rise/fall pulses derived from the synchronised level and a delayed copy.
module spi_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   delay_reg;

  // Shift the raw input through the synchroniser chain and keep a one-cycle-old copy.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sync_reg  <= {SYNC_STAGES{RESET_VAL}};
      delay_reg <= RESET_VAL;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], din};
      delay_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = level & ~delay_reg;
  assign fall  = ~level & delay_reg;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave running on sys_clk and oversampling sclk.
// Deserialises mosi into rx_data and serialises a buffered tx word onto miso.
// Optional feature macro: SPI_SLAVE_UNDERRUN_EN adds the tx_underrun pulse output.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
`ifdef SPI_SLAVE_UNDERRUN_EN
  output logic              tx_underrun,
`endif
  output logic              busy
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int SYNC_N = (SYNC_STAGES < SPI_SYNC_MIN) ? SPI_SYNC_MIN : SYNC_STAGES;

  spi_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0] rx_shift_reg, rx_shift_next;
  logic [DATA_W-1:0] tx_shift_reg, tx_shift_next;
  logic [DATA_W-1:0] rx_data_reg, rx_data_next;
  logic              rx_valid_reg, rx_valid_next;
  logic [DATA_W-1:0] tx_buf_reg, tx_buf_next;
  logic              tx_full_reg, tx_full_next;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic              underrun_reg, underrun_next;
`endif

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_n_sync, cs_n_rise, cs_n_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic sample_pulse, shift_pulse;
  logic start_word;
  logic tx_load;
  logic unused_edges;

  logic [DATA_W-1:0] rx_word;       // rx_shift_reg reordered into word bit positions
  logic [DATA_W-1:0] tx_wire_word;  // tx buffer reordered so bit 0 goes out first

  spi_edge_sync #(.SYNC_STAGES(SYNC_N), .RESET_VAL(SPI_CPOL)) u_sync_sclk (
    .sys_clk (sys_clk),
    .reset   (reset),
    .din     (sclk),
    .level   (sclk_level),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_N), .RESET_VAL(1'b1)) u_sync_cs_n (
    .sys_clk (sys_clk),
    .reset   (reset),
    .din     (cs_n),
    .level   (cs_n_sync),
    .rise    (cs_n_rise),
    .fall    (cs_n_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_N), .RESET_VAL(1'b0)) u_sync_mosi (
    .sys_clk (sys_clk),
    .reset   (reset),
    .din     (mosi),
    .level   (mosi_sync),
    .rise    (mosi_rise),
    .fall    (mosi_fall)
  );

  // Only sclk edges matter; cs_n and mosi are used as levels.
  assign unused_edges = ^{sclk_level, cs_n_rise, cs_n_fall, mosi_rise, mosi_fall};

  // Capture edge vs. launch edge follow from the SPI mode constants.
  assign sample_pulse = (SPI_CPOL == SPI_CPHA) ? sclk_rise : sclk_fall;
  assign shift_pulse  = (SPI_CPOL == SPI_CPHA) ? sclk_fall : sclk_rise;

  // Shift registers always run LSB-first; MSB-first is a pure bit reversal.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_order
      if (LSB_FIRST) begin : g_lsb
        assign rx_word[gi]      = rx_shift_reg[gi];
        assign tx_wire_word[gi] = tx_buf_reg[gi];
      end else begin : g_msb
        assign rx_word[gi]      = rx_shift_reg[DATA_W-1-gi];
        assign tx_wire_word[gi] = tx_buf_reg[DATA_W-1-gi];
      end
    end
  endgenerate

  assign tx_load = tx_valid && !tx_full_reg;

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath updates: word start, bit shifting, completion, abort, tx buffer.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    rx_shift_next = rx_shift_reg;
    tx_shift_next = tx_shift_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    tx_buf_next   = tx_buf_reg;
    tx_full_next  = tx_full_reg;
    start_word    = 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
    underrun_next = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (!cs_n_sync) begin
          start_word = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_n_sync) begin
          // Deselected mid-word: drop the partial word.
          state_next   = IDLE;
          bit_cnt_next = '0;
        end else if (sample_pulse) begin
          rx_shift_next = {mosi_sync, rx_shift_reg[DATA_W-1:1]};
          bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
          if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
            state_next = DONE;
          end
        end else if (shift_pulse && (bit_cnt_reg != '0)) begin
          // The trailing edge left over from the previous word (bit_cnt==0) must
          // not advance the freshly loaded first bit.
          tx_shift_next = {1'b0, tx_shift_reg[DATA_W-1:1]};
        end
      end
      DONE: begin
        rx_data_next  = rx_word;
        rx_valid_next = 1'b1;
        if (!cs_n_sync) begin
          start_word = 1'b1;
        end else begin
          state_next   = IDLE;
          bit_cnt_next = '0;
        end
      end
      default: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
      end
    endcase

    if (start_word) begin
      state_next    = SHIFT;
      bit_cnt_next  = '0;
      tx_shift_next = tx_full_reg ? tx_wire_word : '0;
      tx_full_next  = 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
      underrun_next = !tx_full_reg;
`endif
    end

    // A load can only happen into an empty buffer, so a same-cycle consume
    // has already taken the old (zero) word and the new one stays buffered.
    if (tx_load) begin
      tx_buf_next  = tx_data;
      tx_full_next = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      bit_cnt_reg  <= '0;
      rx_shift_reg <= '0;
      tx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      tx_buf_reg   <= '0;
      tx_full_reg  <= 1'b0;
    end else begin
      bit_cnt_reg  <= bit_cnt_next;
      rx_shift_reg <= rx_shift_next;
      tx_shift_reg <= tx_shift_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      tx_buf_reg   <= tx_buf_next;
      tx_full_reg  <= tx_full_next;
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  // Underrun pulse register.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      underrun_reg <= 1'b0;
    end else begin
      underrun_reg <= underrun_next;
    end
  end

  assign tx_underrun = underrun_reg;
`endif

  assign miso     = (state_reg != IDLE) ? tx_shift_reg[0] : 1'b0;
  assign tx_ready = !tx_full_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: main process drives a mode-0 LSB-first
// master and queues expectations; a monitor process does all comparisons.
module tb_spi_slave;

  localparam int DATA_W = 8;
  localparam int SYNC   = 2;
  localparam int HALF   = 4;

  logic              sys_clk  = 1'b0;
  logic              reset    = 1'b1;
  logic              sclk     = 1'b0;
  logic              cs_n     = 1'b1;
  logic              mosi     = 1'b0;
  logic [DATA_W-1:0] tx_data  = '0;
  logic              tx_valid = 1'b0;
  logic              miso;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic              tx_underrun;
`endif

  spi_slave #(.DATA_W(DATA_W), .LSB_FIRST(1'b1), .SYNC_STAGES(SYNC)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
`ifdef SPI_SLAVE_UNDERRUN_EN
    .tx_underrun (tx_underrun),
`endif
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  chk_t              chk_q[$];
  logic [DATA_W-1:0] exp_rx_q[$];
  int                n_checks     = 0;
  int                n_errors     = 0;
  int                since_rise   = 0;
  int                underrun_cnt = 0;
  logic              sclk_q       = 1'b0;
  bit                done_req     = 1'b0;
  bit                done_ack     = 1'b0;

  // Monitor: all comparisons happen here, on the falling sys_clk edge.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sclk && !sclk_q) since_rise = 0;
      else                 since_rise = since_rise + 1;
      sclk_q = sclk;
`ifdef SPI_SLAVE_UNDERRUN_EN
      if (tx_underrun) underrun_cnt = underrun_cnt + 1;
`endif
      if (rx_valid) begin
        n_checks = n_checks + 1;
        if (exp_rx_q.size() == 0) begin
          n_errors = n_errors + 1;
          $display("FAIL rx_unexpected: got rx_valid with rx_data %02h, required no rx_valid", rx_data);
        end else begin
          logic [DATA_W-1:0] e;
          e = exp_rx_q.pop_front();
          $display("rx word: got %02h expected %02h latency %0d", rx_data, e, since_rise);
          if (rx_data !== e) begin
            n_errors = n_errors + 1;
            $display("FAIL rx_data: got %02h, required %02h", rx_data, e);
          end
          n_checks = n_checks + 1;
          if (since_rise != SYNC + 2) begin
            n_errors = n_errors + 1;
            $display("FAIL rx_latency: got %0d cycles, required %0d", since_rise, SYNC + 2);
          end
        end
      end
      while (chk_q.size() != 0) begin
        chk_t c;
        c = chk_q.pop_front();
        n_checks = n_checks + 1;
        if (c.act !== c.exp) begin
          n_errors = n_errors + 1;
          $display("FAIL %s: got %0h, required %0h", c.name, c.act, c.exp);
        end
      end
      if (done_req && !done_ack) begin
        n_checks = n_checks + 1;
        if (exp_rx_q.size() != 0) begin
          n_errors = n_errors + 1;
          $display("FAIL rx_missing: got %0d words outstanding, required 0", exp_rx_q.size());
        end
        done_ack = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_q.push_back('{name, act, exp});
  endtask

  task automatic load_tx(input logic [DATA_W-1:0] w);
    tx_data  = w;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    tick(6);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    tick(8);
  endtask

  // Mode-0, LSB-first master: mosi set while sclk low, miso captured at rise.
  task automatic xfer(input logic [DATA_W-1:0] w, input int nbits, output logic [DATA_W-1:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[i];
      tick(HALF);
      sclk   = 1'b1;
      got[i] = miso;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  initial begin
    logic [DATA_W-1:0] got;
    int u0;

    tick(4);
    reset = 1'b0;
    tick(1);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_miso", miso, 0);

    // 1: empty tx buffer, receive A5, slave sends zeros.
    u0 = underrun_cnt;
    cs_low();
    check("t1_busy", busy, 1);
`ifdef SPI_SLAVE_UNDERRUN_EN
    check("t1_underrun_pulse", underrun_cnt - u0, 1);
`endif
    exp_rx_q.push_back(8'hA5);
    xfer(8'hA5, 8, got);
    check("t1_miso_word", got, 8'h00);
    cs_high();
    check("t1_idle", busy, 0);

    // 2: preloaded 3C goes out while 00 comes in.
    load_tx(8'h3C);
    check("t2_tx_ready_loaded", tx_ready, 0);
    u0 = underrun_cnt;
    cs_low();
    check("t2_tx_ready_consumed", tx_ready, 1);
`ifdef SPI_SLAVE_UNDERRUN_EN
    check("t2_no_underrun", underrun_cnt - u0, 0);
`endif
    exp_rx_q.push_back(8'h00);
    xfer(8'h00, 8, got);
    check("t2_miso_word", got, 8'h3C);
    cs_high();

    // 3: back-to-back words with tx reload between them.
    load_tx(8'h5C);
    cs_low();
    load_tx(8'hC3);
    check("t3_tx_ready_second", tx_ready, 0);
    exp_rx_q.push_back(8'h12);
    xfer(8'h12, 8, got);
    check("t3_miso_word1", got, 8'h5C);
    exp_rx_q.push_back(8'h34);
    xfer(8'h34, 8, got);
    check("t3_miso_word2", got, 8'hC3);
    cs_high();

    // 4: abort after 5 bits of FF.
    load_tx(8'h99);
    cs_low();
    xfer(8'hFF, 5, got);
    check("t4_miso_partial", got, 8'h19);
    cs_n = 1'b1;
    tick(6);
    check("t4_busy", busy, 0);
    check("t4_miso", miso, 0);
    check("t4_rx_data_held", rx_data, 8'h34);
    check("t4_tx_ready", tx_ready, 1);
    tick(4);

    // 5: reset after 3 bits, then a clean word.
    cs_low();
    xfer(8'hAA, 3, got);
    load_tx(8'h77);
    check("t5_tx_ready_pre", tx_ready, 0);
    reset = 1'b1;
    cs_n  = 1'b1;
    tick(1);
    check("t5_rst_miso", miso, 0);
    check("t5_rst_tx_ready", tx_ready, 1);
    check("t5_rst_rx_data", rx_data, 0);
    check("t5_rst_rx_valid", rx_valid, 0);
    check("t5_rst_busy", busy, 0);
    reset = 1'b0;
    tick(4);
    cs_low();
    exp_rx_q.push_back(8'h5A);
    xfer(8'h5A, 8, got);
    check("t5_miso_word", got, 8'h00);
    cs_high();
    check("t5_rx_data", rx_data, 8'h5A);

    tick(10);
    done_req = 1'b1;
    for (int i = 0; i < 100 && !done_ack; i++) tick(1);
    if (!done_ack) begin
      $display("FAIL monitor_done: got no acknowledge, required acknowledge within 100 cycles");
      $fatal(1, "monitor did not respond");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
